// File: rtl/free_list_ctrl_pkg.sv
// Shared sizing and types for the physical-register free list.
// Define FREE_LIST_DUP_CHECK_EN to build in the double-release bitmap.
`ifndef PROJ_NUM_PHYS_REGS
`define PROJ_NUM_PHYS_REGS 64
`endif
`ifndef PROJ_NUM_ARCH_REGS
`define PROJ_NUM_ARCH_REGS 32
`endif
`ifndef PROJ_LOG_PHYS
`define PROJ_LOG_PHYS 6
`endif
`ifndef FREE_LIST_DEPTH
`define FREE_LIST_DEPTH (`PROJ_NUM_PHYS_REGS - `PROJ_NUM_ARCH_REGS)
`endif

package free_list_ctrl_pkg;

  localparam int NUM_PHYS = `PROJ_NUM_PHYS_REGS;
  localparam int NUM_ARCH = `PROJ_NUM_ARCH_REGS;
  localparam int DEPTH    = `FREE_LIST_DEPTH;
  localparam int IDX_W    = $clog2(DEPTH);
  localparam int PTR_W    = IDX_W + 1;
  localparam int TAG_W    = `PROJ_LOG_PHYS;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic alloc;
    logic rel;
    logic commit;
  } err_t;

  function automatic logic [IDX_W-1:0] ptr_idx(input ptr_t p);
    return p[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/free_list_ptr.sv
// Wrapping free-list pointer: MSB is the lap bit, low bits index the buffer.
module free_list_ptr
  import free_list_ctrl_pkg::*;
#(
  parameter ptr_t RST_VAL = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic load,
  input  ptr_t load_val,
  output ptr_t value
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= RST_VAL;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/free_list_ctrl.sv
// Free-list controller: speculative alloc, committed head for flush recovery,
// tail for retirement releases. FREE_LIST_DUP_CHECK_EN adds double-release detection.
module free_list_ctrl
  import free_list_ctrl_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Alloc_req,
  output logic [TAG_W-1:0] Alloc_reg,
  output logic             Free_reg_avail,
  output logic [PTR_W-1:0] Free_count,
  input  logic             Commit_alloc,
  input  logic             Release_valid,
  input  logic [TAG_W-1:0] Release_reg,
  input  logic             Flush,
  output logic             Error
);

  tag_t mem [DEPTH];
  ptr_t spec_head;
  ptr_t commit_head;
  ptr_t tail;
  ptr_t commit_next;
  ptr_t commit_used;
  logic alloc_ok;
  logic commit_ok;
  logic release_ok;
  logic release_room;
  logic release_tag_ok;
  err_t err_next;

  assign Free_count     = tail - spec_head;
  assign commit_used    = tail - commit_head;
  assign Free_reg_avail = (Free_count != '0);
  assign Alloc_reg      = mem[ptr_idx(spec_head)];
  assign release_room   = (commit_used < ptr_t'(DEPTH));

  assign alloc_ok    = Alloc_req && Free_reg_avail && !Flush;
  assign commit_ok   = Commit_alloc && (commit_head != spec_head);
  assign release_ok  = Release_valid && release_room && release_tag_ok;
  // Flush rewinds to the commit head including this cycle's retirement.
  assign commit_next = commit_head + ptr_t'(commit_ok);

  assign err_next.alloc  = Alloc_req && !Free_reg_avail && !Flush;
  assign err_next.rel    = Release_valid && !release_ok;
  assign err_next.commit = Commit_alloc && !commit_ok;

`ifdef FREE_LIST_DUP_CHECK_EN
  logic [NUM_PHYS-1:0] not_alloc;

  assign release_tag_ok = (Release_reg != '0) && !not_alloc[Release_reg];

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_PHYS; i++) begin
        not_alloc[i] <= (i >= NUM_ARCH);
      end
    end else begin
      if (commit_ok) begin
        not_alloc[mem[ptr_idx(commit_head)]] <= 1'b0;
      end
      if (release_ok) begin
        not_alloc[Release_reg] <= 1'b1;
      end
    end
  end
`else
  assign release_tag_ok = 1'b1;
`endif

  free_list_ptr #(.RST_VAL('0)) u_spec_head (
    .clk      (CLK),
    .rst_n    (RESET),
    .inc      (alloc_ok),
    .load     (Flush),
    .load_val (commit_next),
    .value    (spec_head)
  );

  free_list_ptr #(.RST_VAL('0)) u_commit_head (
    .clk      (CLK),
    .rst_n    (RESET),
    .inc      (commit_ok),
    .load     (1'b0),
    .load_val ('0),
    .value    (commit_head)
  );

  free_list_ptr #(.RST_VAL(ptr_t'(DEPTH))) u_tail (
    .clk      (CLK),
    .rst_n    (RESET),
    .inc      (release_ok),
    .load     (1'b0),
    .load_val ('0),
    .value    (tail)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= tag_t'(NUM_ARCH + i);
      end
    end else if (release_ok) begin
      mem[ptr_idx(tail)] <= Release_reg;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      Error <= 1'b0;
    end else begin
      Error <= err_next.alloc | err_next.rel | err_next.commit;
    end
  end

endmodule

// File: tb/tb_free_list_ctrl.sv
// Directed bench for free_list_ctrl: vector table plus hand-written corner sequences.
module tb_free_list_ctrl;

  logic       clk;
  logic       rst;
  logic       alloc_req;
  logic [5:0] alloc_reg;
  logic       avail;
  logic [5:0] free_count;
  logic       commit_alloc;
  logic       release_valid;
  logic [5:0] release_reg;
  logic       flush;
  logic       error;

  int n_checks;
  int n_pass;

  free_list_ctrl dut (
    .CLK            (clk),
    .RESET          (rst),
    .Alloc_req      (alloc_req),
    .Alloc_reg      (alloc_reg),
    .Free_reg_avail (avail),
    .Free_count     (free_count),
    .Commit_alloc   (commit_alloc),
    .Release_valid  (release_valid),
    .Release_reg    (release_reg),
    .Flush          (flush),
    .Error          (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a, c, rv, rr, f;
    int e_reg, e_av, e_cnt, e_err;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic cycle(input int a, input int c, input int rv, input int rr, input int f);
    alloc_req     = (a != 0);
    commit_alloc  = (c != 0);
    release_valid = (rv != 0);
    release_reg   = 6'(rr);
    flush         = (f != 0);
    @(posedge clk);
    #1;
    alloc_req     = 1'b0;
    commit_alloc  = 1'b0;
    release_valid = 1'b0;
    release_reg   = '0;
    flush         = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  int free_q[$];
  int inflight_q[$];
  int owned_q[$];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    alloc_req = 1'b0; commit_alloc = 1'b0; release_valid = 1'b0;
    release_reg = '0; flush = 1'b0; rst = 1'b0;

    //          a  c rv rr f   reg av cnt err
    vecs[0]  = '{1, 0, 0, 0, 0, 33, 1, 31, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 34, 1, 30, 0};
    vecs[2]  = '{1, 0, 0, 0, 0, 35, 1, 29, 0};
    vecs[3]  = '{1, 0, 0, 0, 0, 36, 1, 28, 0};
    vecs[4]  = '{1, 0, 0, 0, 0, 37, 1, 27, 0};
    vecs[5]  = '{0, 1, 0, 0, 0, 37, 1, 27, 0};
    vecs[6]  = '{0, 1, 0, 0, 0, 37, 1, 27, 0};
    vecs[7]  = '{0, 0, 0, 0, 1, 34, 1, 30, 0};
    vecs[8]  = '{1, 0, 0, 0, 1, 34, 1, 30, 0};
    vecs[9]  = '{1, 0, 0, 0, 0, 35, 1, 29, 0};
    vecs[10] = '{0, 1, 0, 0, 1, 35, 1, 29, 0};
    vecs[11] = '{0, 1, 0, 0, 0, 35, 1, 29, 1};
    vecs[12] = '{0, 0, 1, 5, 0, 35, 1, 30, 0};
    vecs[13] = '{0, 0, 1, 6, 0, 35, 1, 31, 0};
    vecs[14] = '{0, 0, 1, 9, 0, 35, 1, 32, 0};
    vecs[15] = '{0, 0, 1, 10, 0, 35, 1, 32, 1};
    vecs[16] = '{1, 0, 0, 0, 0, 36, 1, 31, 0};
    vecs[17] = '{0, 1, 0, 0, 0, 36, 1, 31, 0};
    vecs[18] = '{1, 0, 1, 11, 0, 37, 1, 31, 0};

    // Reset state
    do_reset();
    check("reset_count", int'(free_count), 32);
    check("reset_avail", int'(avail), 1);
    check("reset_alloc_reg", int'(alloc_reg), 32);
    check("reset_error", int'(error), 0);

    // Drain the list in order, then over-allocate
    for (int i = 0; i < 32; i++) begin
      check("drain_alloc_reg", int'(alloc_reg), 32 + i);
      cycle(1, 0, 0, 0, 0);
    end
    check("empty_avail", int'(avail), 0);
    check("empty_count", int'(free_count), 0);
    cycle(1, 0, 0, 0, 0);
    check("overalloc_error", int'(error), 1);
    check("overalloc_count", int'(free_count), 0);
    check("overalloc_head", int'(alloc_reg), 32);
    cycle(0, 0, 0, 0, 0);
    check("error_pulse_end", int'(error), 0);

    // Make room on the commit side, then alloc + release on an empty list
    cycle(0, 1, 0, 0, 0);
    check("commit_error", int'(error), 0);
    check("commit_count", int'(free_count), 0);
    check("no_bypass_avail", int'(avail), 0);
    cycle(1, 0, 1, 7, 0);
    check("empty_alloc_rel_error", int'(error), 1);
    check("empty_alloc_rel_count", int'(free_count), 1);
    check("empty_alloc_rel_reg", int'(alloc_reg), 7);
    check("empty_alloc_rel_avail", int'(avail), 1);
    cycle(0, 0, 0, 0, 0);
    check("empty_alloc_rel_pulse", int'(error), 0);

    // Mid-operation reset discards state, then the vector table
    do_reset();
    check("rereset_count", int'(free_count), 32);
    check("rereset_alloc_reg", int'(alloc_reg), 32);
    for (int i = 0; i < 19; i++) begin
      cycle(vecs[i].a, vecs[i].c, vecs[i].rv, vecs[i].rr, vecs[i].f);
      check($sformatf("vec%0d_reg", i), int'(alloc_reg), vecs[i].e_reg);
      check($sformatf("vec%0d_avail", i), int'(avail), vecs[i].e_av);
      check($sformatf("vec%0d_count", i), int'(free_count), vecs[i].e_cnt);
      check($sformatf("vec%0d_error", i), int'(error), vecs[i].e_err);
    end

    // Long alloc/commit/release run across several buffer and pointer wraps
    do_reset();
    free_q.delete(); inflight_q.delete(); owned_q.delete();
    for (int t = 32; t < 64; t++) free_q.push_back(t);
    for (int t = 1; t < 32; t++) owned_q.push_back(t);
    for (int i = 0; i < 100; i++) begin
      int c;
      int r;
      int rr;
      c  = (i >= 1) ? 1 : 0;
      r  = (i >= 2) ? 1 : 0;
      rr = (r != 0) ? owned_q.pop_front() : 0;
      check($sformatf("wrap%0d_head", i), int'(alloc_reg), free_q[0]);
      cycle(1, c, r, rr, 0);
      inflight_q.push_back(free_q.pop_front());
      if (c != 0) owned_q.push_back(inflight_q.pop_front());
      if (r != 0) free_q.push_back(rr);
      check($sformatf("wrap%0d_count", i), int'(free_count), free_q.size());
      check($sformatf("wrap%0d_error", i), int'(error), 0);
    end
    check("wrap_steady_count", int'(free_count), 30);

`ifdef FREE_LIST_DUP_CHECK_EN
    do_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 40, 0);
    check("dup_free_error", int'(error), 1);
    check("dup_free_count", int'(free_count), 31);
    cycle(0, 0, 1, 0, 0);
    check("tag0_error", int'(error), 1);
    check("tag0_count", int'(free_count), 31);
    cycle(0, 0, 1, 32, 0);
    check("legal_release_error", int'(error), 0);
    check("legal_release_count", int'(free_count), 32);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
